instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch front end with an in-order
// response buffer and redirect flushing.
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// in ERR. Without it the two low target bits are ignored.
//
// state | meaning
// IDLE  | first cycle after reset, no requests issued
// FETCH | issue requests while buffer plus in-flight stays below FIFO_DEPTH
// ERR   | misaligned redirect seen, requests halted until an aligned redirect

module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_misaligned_o
);

  localparam int unsigned     PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERR   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // each entry holds {pc, instruction}
  logic [XLEN+31:0] fifo_mem [FIFO_DEPTH];

  logic [XLEN-1:0] redir_pc;
  logic            redir_misaligned;
  logic            fifo_empty;
  logic            room;
  logic            grant;
  logic            resp_drop;
  logic            push;
  logic            pop;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_misaligned   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign fetch_misaligned_o = (state_q == ERR);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb   = ^redirect_pc_i[1:0];
  assign redir_misaligned   = 1'b0;
  assign fetch_misaligned_o = 1'b0;
`endif

  // the PC registers only ever hold word-aligned addresses
  assign redir_pc    = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_addr_o = fetch_pc_q;

  // Head of buffer drives decode directly; masked to zero when empty.
  assign {instr_pc_o, instr_o} = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  // Request gating, response classification and decode handshake.
  always_comb begin
    fifo_empty    = (count_q == '0);
    room          = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    imem_req_o    = (state_q == FETCH) && !redirect_i && room;
    grant         = imem_req_o && imem_gnt_i;
    resp_drop     = imem_rvalid_i && (discard_cnt_q != '0);
    // a response arriving with a redirect belongs to the old stream
    push          = imem_rvalid_i && !resp_drop && !redirect_i;
    instr_valid_o = !fifo_empty && !redirect_i;
    pop           = instr_valid_o && instr_ready_i;
  end

  // Next values for PCs, counters and buffer pointers.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_cnt_d = discard_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    // outstanding counts every request in flight, stale or live
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
    if (redirect_i) begin
      fetch_pc_d    = redir_pc;
      resp_pc_d     = redir_pc;
      // everything still in flight after this cycle is from the old stream
      discard_cnt_d = outstanding_d;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)  resp_pc_d  = resp_pc_q + PC_STEP;
      discard_cnt_d = discard_cnt_q - CNT_W'(resp_drop);
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d      = wr_ptr_q + PTR_W'(push);
      rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    end
  end

  // FSM next state; a redirect overrides from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (redirect_i) begin
      state_d = redir_misaligned ? ERR : FETCH;
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage write; contents are only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {resp_pc_q, imem_rdata_i};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with a stream-level reference model.
// Fetched addresses carry an epoch tag; a redirect starts a new epoch and only
// responses from the current epoch may reach decode, in address order.

module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        fetch_misaligned_o;

  instr_fetch_unit dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .instr_valid_o      (instr_valid_o),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_ready_i      (instr_ready_i),
    .fetch_misaligned_o (fetch_misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];
  logic [31:0] model_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] deliv_log[$];
  logic [31:0] deliv_cyc[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle    = 0;
  int          epoch    = 0;
  logic [31:0] exp_fetch_pc;
  bit          fetching;
  bit          err_st;
  int          p_gnt = 100, p_ready = 100, p_rvalid = 100;
  int          lat_min = 1, lat_max = 1;
  bit          redir_now = 1'b0;
  logic [31:0] redir_pc_now = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset();
    rstn_i        = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    mem_q.delete();
    model_q.delete();
    epoch++;
    exp_fetch_pc = 32'h0;
    fetching     = 1'b0;
    err_st       = 1'b0;
    redir_now    = 1'b0;
    #2;
    check_eq("rst_req", imem_req_o, 1'b0);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
    check_eq("rst_misal", fetch_misaligned_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    cycle++;
    @(negedge clk_i);
    check_eq("idle_req", imem_req_o, 1'b0);
    check_eq("idle_valid", instr_valid_o, 1'b0);
    fetching = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    bit       rv, exp_req, exp_valid, rdy, gnt;
    mem_rsp_t r;
    @(posedge clk_i);
    #1;
    cycle++;
    rdy = ($urandom_range(99) < p_ready);
    gnt = ($urandom_range(99) < p_gnt);
    rv  = (mem_q.size() > 0) && (mem_q[0].due <= cycle) && ($urandom_range(99) < p_rvalid);
    redirect_i    = redir_now;
    redirect_pc_i = redir_pc_now;
    instr_ready_i = rdy;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_fn(mem_q[0].addr) : $urandom();
    @(negedge clk_i);
    exp_req = fetching && !err_st && !redir_now && ((model_q.size() + mem_q.size()) < DEPTH);
    check_eq("imem_req", imem_req_o, exp_req);
    check_eq("imem_addr", imem_addr_o, exp_fetch_pc);
    exp_valid = (model_q.size() > 0) && !redir_now;
    check_eq("instr_valid", instr_valid_o, exp_valid);
    if (exp_valid) begin
      check_eq("instr_pc", instr_pc_o, model_q[0]);
      check_eq("instr", instr_o, mem_fn(model_q[0]));
    end
    check_eq("misaligned", fetch_misaligned_o, err_st);
    if (exp_valid && rdy) begin
      deliv_log.push_back(model_q[0]);
      deliv_cyc.push_back(cycle);
      void'(model_q.pop_front());
    end
    if (rv) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !redir_now) model_q.push_back(r.addr);
    end
    if (exp_req && gnt) begin
      grant_log.push_back(exp_fetch_pc);
      mem_q.push_back('{addr: exp_fetch_pc, epoch: epoch,
                        due: cycle + int'($urandom_range(lat_max, lat_min))});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redir_now) begin
      epoch++;
      model_q.delete();
      exp_fetch_pc = {redir_pc_now[31:2], 2'b00};
      err_st       = ALIGN_EN && (redir_pc_now[1:0] != 2'b00);
    end
    redir_now = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir_now    = 1'b1;
    redir_pc_now = pc;
    step();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    deliv_log.delete();
    deliv_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int waited;

    // reset, then full-rate stream from address 0
    do_reset();
    clear_logs();
    c0 = cycle + 1;
    repeat (10) step();
    check_eq("boot_grant0", q_at(grant_log, 0), 32'h0);
    check_eq("boot_pc0", q_at(deliv_log, 0), 32'h0);
    check_eq("boot_pc1", q_at(deliv_log, 1), 32'h4);
    check_eq("boot_pc2", q_at(deliv_log, 2), 32'h8);
    check_eq("boot_cyc0", q_at(deliv_cyc, 0), 32'(c0 + 2));
    check_eq("boot_cyc1", q_at(deliv_cyc, 1), 32'(c0 + 3));
    check_eq("boot_cyc2", q_at(deliv_cyc, 2), 32'(c0 + 4));

    // backpressure: decode stalled, at most DEPTH requests accepted
    p_ready = 0;
    redirect_to(32'h300);
    clear_logs();
    repeat (12) step();
    check_eq("bp_grants", grant_log.size(), DEPTH);
    check_eq("bp_req_off", imem_req_o, 1'b0);
    p_ready = 100;
    clear_logs();
    repeat (20) step();
    for (int i = 0; i < 8; i++) begin
      check_eq("bp_resume_pc", q_at(deliv_log, i), 32'h300 + 32'(4 * i));
    end

    // redirect with three requests in flight
    lat_min = 5; lat_max = 5;
    redirect_to(32'h1000);
    clear_logs();
    waited = 0;
    while (grant_log.size() < 3 && waited < 20) begin
      step();
      waited++;
    end
    check_eq("redir_inflight", grant_log.size(), 3);
    clear_logs();
    redirect_to(32'h100);
    repeat (30) step();
    check_eq("redir_first_pc", q_at(deliv_log, 0), 32'h100);

    // double redirect two cycles apart with responses pending
    lat_min = 4; lat_max = 4;
    redirect_to(32'h40);
    clear_logs();
    step();
    redirect_to(32'h80);
    repeat (30) step();
    check_eq("dbl_first_pc", q_at(deliv_log, 0), 32'h80);
    for (int i = 0; i < deliv_log.size(); i++) begin
      check_eq("dbl_not_stale", deliv_log[i] >= 32'h80, 1'b1);
    end

    // misaligned redirect target
    lat_min = 2; lat_max = 2;
    clear_logs();
    redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (6) step();
    check_eq("misal_flag", fetch_misaligned_o, 1'b1);
    check_eq("misal_no_req", grant_log.size(), 0);
    clear_logs();
    redirect_to(32'h200);
    repeat (20) step();
    check_eq("misal_clear", fetch_misaligned_o, 1'b0);
    check_eq("misal_grant0", q_at(grant_log, 0), 32'h200);
    check_eq("misal_pc0", q_at(deliv_log, 0), 32'h200);
`else
    repeat (20) step();
    check_eq("misal_flag", fetch_misaligned_o, 1'b0);
    check_eq("misal_grant0", q_at(grant_log, 0), 32'h100);
    check_eq("misal_pc0", q_at(deliv_log, 0), 32'h100);
`endif

    // address wrap
    lat_min = 1; lat_max = 1;
    clear_logs();
    redirect_to(32'hFFFF_FFFC);
    repeat (12) step();
    check_eq("wrap_grant0", q_at(grant_log, 0), 32'hFFFF_FFFC);
    check_eq("wrap_grant1", q_at(grant_log, 1), 32'h0000_0000);
    check_eq("wrap_grant2", q_at(grant_log, 2), 32'h0000_0004);
    check_eq("wrap_pc0", q_at(deliv_log, 0), 32'hFFFF_FFFC);
    check_eq("wrap_pc1", q_at(deliv_log, 1), 32'h0000_0000);
    check_eq("wrap_pc2", q_at(deliv_log, 2), 32'h0000_0004);

    // random traffic with redirects and one mid-stream reset
    for (int i = 0; i < 2400; i++) begin
      if (i % 64 == 0) begin
        p_gnt    = int'($urandom_range(100, 20));
        p_ready  = int'($urandom_range(100, 0));
        p_rvalid = int'($urandom_range(100, 30));
        lat_min  = int'($urandom_range(3, 1));
        lat_max  = lat_min + int'($urandom_range(4, 0));
      end
      if (i == 1200) begin
        do_reset();
      end else if ($urandom_range(99) < 3) begin
        logic [31:0] tgt;
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                       : $urandom();
        if ($urandom_range(4) != 0) tgt[1:0] = 2'b00;
        redirect_to(tgt);
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
